// File: rtl/test_harness.sv
// Scratchpad self-test harness. It fills a RAM with an LFSR sequence and reads it back
// against a regenerated copy. io_success rises only when every word matches.
module test_harness #(
  parameter int          DEPTH        = 16,
  parameter logic [31:0] SEED         = 32'h0000_0001,
  parameter int          START_DELAY  = 4,
  parameter bit          FAULT_INJECT = 1'b0
) (
  input  logic clock,
  input  logic reset,
  output logic io_success
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [31:0] EFF_SEED  = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [7:0]  DELAY     = 8'(START_DELAY);
  localparam logic [31:0] TAPS      = 32'h8020_0003;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    CHECK = 3'd3,
    PASS  = 3'd4,
    FAIL  = 3'd5
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   addr_q;
  logic [7:0]      delay_q;
  logic [31:0]     lfsr_q;
  logic [31:0]     lfsrDly_q;
  logic [31:0]     rdata_q;
  logic            cmpValid_q;
  logic            err_q;
  logic            success_q;
  logic [31:0]     mem_q [DEPTH];

  logic [31:0]     lfsrNext;
  logic [31:0]     writeData;
  logic            wordMismatch;

  assign lfsrNext     = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
  assign writeData    = lfsr_q ^ {31'b0, FAULT_INJECT && (addr_q == LAST_ADDR)};
  assign wordMismatch = cmpValid_q && (rdata_q != lfsrDly_q);
  assign io_success   = success_q;

  // Single-port scratchpad: contents are never reset, read data lands one cycle later.
  always_ff @(posedge clock) begin
    if (state_q == WRITE) begin
      mem_q[addr_q] <= writeData;
    end
    rdata_q <= mem_q[addr_q];
  end

  // Returned words are compared one cycle after their read, hence the delayed LFSR copy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      delay_q    <= '0;
      lfsr_q     <= EFF_SEED;
      lfsrDly_q  <= '0;
      cmpValid_q <= 1'b0;
      err_q      <= 1'b0;
      success_q  <= 1'b0;
    end else begin
      lfsrDly_q  <= lfsr_q;
      cmpValid_q <= (state_q == READ);
      case (state_q)
        IDLE: begin
          if (delay_q == DELAY) begin
            state_q <= WRITE;
            lfsr_q  <= EFF_SEED;
            addr_q  <= '0;
          end else begin
            delay_q <= delay_q + 8'd1;
          end
        end
        WRITE: begin
          lfsr_q <= lfsrNext;
          addr_q <= addr_q + 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_q <= READ;
            lfsr_q  <= EFF_SEED;
            addr_q  <= '0;
          end
        end
        READ: begin
          lfsr_q <= lfsrNext;
          addr_q <= addr_q + 1'b1;
          if (wordMismatch) begin
            err_q <= 1'b1;
          end
          if (addr_q == LAST_ADDR) begin
            state_q <= CHECK;
            addr_q  <= '0;
          end
        end
        CHECK: begin
          if (err_q || wordMismatch) begin
            state_q   <= FAIL;
            success_q <= 1'b0;
          end else begin
            state_q   <= PASS;
            success_q <= 1'b1;
          end
        end
        PASS: begin
          success_q <= 1'b1;
        end
        FAIL: begin
          success_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          success_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test_harness.sv
// Bench for test_harness: four configurations share clock and reset, and a per-edge
// queue of expected io_success values is popped against each instance.
module tb_test_harness;

  localparam int NEVER = 1 << 30;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic succDef;
  logic succFault;
  logic succSmall;
  logic succBig;

  int checks = 0;
  int errors = 0;

  bit expDef[$];
  bit expFault[$];
  bit expSmall[$];
  bit expBig[$];

  logic [31:0] modelWord;

  always #5 clock = ~clock;

  test_harness #(.DEPTH(16), .SEED(32'h1), .START_DELAY(4), .FAULT_INJECT(1'b0)) dutDef (
    .clock(clock), .reset(reset), .io_success(succDef));
  test_harness #(.DEPTH(16), .SEED(32'h1), .START_DELAY(4), .FAULT_INJECT(1'b1)) dutFault (
    .clock(clock), .reset(reset), .io_success(succFault));
  test_harness #(.DEPTH(2), .SEED(32'h0), .START_DELAY(0), .FAULT_INJECT(1'b0)) dutSmall (
    .clock(clock), .reset(reset), .io_success(succSmall));
  test_harness #(.DEPTH(256), .SEED(32'hDEAD_BEEF), .START_DELAY(4), .FAULT_INJECT(1'b0)) dutBig (
    .clock(clock), .reset(reset), .io_success(succBig));

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkWord(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Edge numbers count from 1 within the upcoming stretch; a rise of NEVER keeps the flag low.
  task automatic pushExpect(input int edges, input int riseDef, input int riseFault,
                            input int riseSmall, input int riseBig);
    for (int e = 1; e <= edges; e++) begin
      expDef.push_back(e >= riseDef);
      expFault.push_back(e >= riseFault);
      expSmall.push_back(e >= riseSmall);
      expBig.push_back(e >= riseBig);
    end
  endtask

  task automatic applyStimulus(input logic rst, input int edges);
    reset = rst;
    for (int i = 0; i < edges; i++) begin
      @(posedge clock);
      #1;
      if (expDef.size() > 0)   checkOutput("defSuccess", succDef, expDef.pop_front());
      if (expFault.size() > 0) checkOutput("faultSuccess", succFault, expFault.pop_front());
      if (expSmall.size() > 0) checkOutput("smallSuccess", succSmall, expSmall.pop_front());
      if (expBig.size() > 0)   checkOutput("bigSuccess", succBig, expBig.pop_front());
    end
  endtask

  initial begin
    $display("[TB] starting test_harness bench");

    pushExpect(5, NEVER, NEVER, NEVER, NEVER);
    applyStimulus(1'b0, 5);

    pushExpect(1000, 38, NEVER, 6, 518);
    applyStimulus(1'b1, 6);
    checkWord("smallMem0", dutSmall.mem_q[0], 32'h0000_0001);
    checkWord("smallMem1", dutSmall.mem_q[1], 32'h8020_0003);
    applyStimulus(1'b1, 32);

    // Word 15 of the seed-1 sequence, stepped by the bench's own Galois model.
    modelWord = 32'h1;
    for (int s = 0; s < 15; s++) begin
      modelWord = {1'b0, modelWord[31:1]} ^ (modelWord[0] ? 32'h8020_0003 : 32'h0);
    end
    checkWord("defMem15", dutDef.mem_q[15], modelWord);
    checkWord("faultMem15", dutFault.mem_q[15], modelWord ^ 32'h1);
    checkWord("faultState", {29'b0, dutFault.state_q}, 32'd5);
    applyStimulus(1'b1, 962);

    pushExpect(3, NEVER, NEVER, NEVER, NEVER);
    applyStimulus(1'b0, 3);
    pushExpect(47, 38, NEVER, 6, NEVER);
    applyStimulus(1'b1, 47);

    pushExpect(2, NEVER, NEVER, NEVER, NEVER);
    applyStimulus(1'b0, 2);
    pushExpect(19, NEVER, NEVER, 6, NEVER);
    applyStimulus(1'b1, 19);
    pushExpect(2, NEVER, NEVER, NEVER, NEVER);
    applyStimulus(1'b0, 2);
    pushExpect(40, 38, NEVER, 6, NEVER);
    applyStimulus(1'b1, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
